// File: rtl/buffer_circular_pkg.sv
// Shared constants and index helpers for the circular buffer family.
package buffer_circular_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_NUM   = 8;

  // Explicit wrap so non-power-of-two depths never index past NUM-1
  function automatic int unsigned siguiente_indice(input int unsigned idx,
                                                   input int unsigned num);
    return (idx == num - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/buffer_circular_ctrl.sv
// Pointer, occupancy, status-flag and sticky-error control for the circular buffer.
module buffer_circular_ctrl
  import buffer_circular_pkg::*;
#(
  parameter int NUM          = DEF_NUM,
  parameter int UMBRAL_LLENA = NUM - 2,
  parameter int UMBRAL_VACIA = 1,
  localparam int INDEX_SIZE  = $clog2(NUM),
  localparam int COUNT_SIZE  = $clog2(NUM + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vaciar_i,
  input  logic                  insercion_i,
  input  logic                  delecion_i,
  output logic [INDEX_SIZE-1:0] head_o,
  output logic [INDEX_SIZE-1:0] tail_o,
  output logic                  wr_en_o,
  output logic                  vacia_o,
  output logic                  llena_o,
  output logic                  casi_llena_o,
  output logic                  casi_vacia_o,
  output logic [COUNT_SIZE-1:0] num_o,
  output logic                  desbordamiento_o,
  output logic                  subdesbordamiento_o
);

  localparam logic [COUNT_SIZE-1:0] NUM_C    = COUNT_SIZE'(NUM);
  localparam logic [COUNT_SIZE-1:0] LLENA_C  = COUNT_SIZE'(UMBRAL_LLENA);
  localparam logic [COUNT_SIZE-1:0] VACIA_C  = COUNT_SIZE'(UMBRAL_VACIA);

  logic [INDEX_SIZE-1:0] head_q, head_d, tail_q, tail_d;
  logic [COUNT_SIZE-1:0] num_q, num_d;
  logic                  desb_q, desb_d, subd_q, subd_d;
  logic                  permiso_delecion, permiso_insercion;

  assign vacia_o      = (num_q == '0);
  assign llena_o      = (num_q == NUM_C) | rst_i;
  assign casi_llena_o = (num_q >= LLENA_C);
  assign casi_vacia_o = (num_q <= VACIA_C);

  // A delete on a full buffer frees the slot in the same cycle
  assign permiso_delecion  = delecion_i & ~vacia_o;
  assign permiso_insercion = insercion_i & (~llena_o | delecion_i);
  assign wr_en_o           = permiso_insercion & ~vaciar_i & ~rst_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    num_d  = num_q;
    if (vaciar_i) begin
      head_d = '0;
      tail_d = '0;
      num_d  = '0;
    end else begin
      if (permiso_delecion)
        head_d = INDEX_SIZE'(siguiente_indice(32'(head_q), NUM));
      if (permiso_insercion)
        tail_d = INDEX_SIZE'(siguiente_indice(32'(tail_q), NUM));
      num_d = num_q + COUNT_SIZE'(permiso_insercion) - COUNT_SIZE'(permiso_delecion);
    end
    desb_d = desb_q | (insercion_i & (num_q == NUM_C) & ~delecion_i & ~vaciar_i);
    subd_d = subd_q | (delecion_i & (num_q == '0) & ~vaciar_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      num_q  <= '0;
      desb_q <= 1'b0;
      subd_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      num_q  <= num_d;
      desb_q <= desb_d;
      subd_q <= subd_d;
    end
  end

  assign head_o              = head_q;
  assign tail_o              = tail_q;
  assign num_o               = num_q;
  assign desbordamiento_o    = desb_q;
  assign subdesbordamiento_o = subd_q;

endmodule

// File: rtl/buffer_circular_param.sv
// Parametrised first-word-fall-through circular FIFO: storage array plus read mux.
module buffer_circular_param
  import buffer_circular_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int NUM          = DEF_NUM,
  parameter int UMBRAL_LLENA = NUM - 2,
  parameter int UMBRAL_VACIA = 1,
  localparam int INDEX_SIZE  = $clog2(NUM),
  localparam int COUNT_SIZE  = $clog2(NUM + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vaciar_i,
  input  logic                  insercion_i,
  input  logic [WIDTH-1:0]      dato_i,
  input  logic                  delecion_i,
  output logic [WIDTH-1:0]      dato_o,
  output logic                  vacia_o,
  output logic                  llena_o,
  output logic                  casi_llena_o,
  output logic                  casi_vacia_o,
  output logic [COUNT_SIZE-1:0] num_o,
  output logic                  desbordamiento_o,
  output logic                  subdesbordamiento_o
);

  logic [INDEX_SIZE-1:0] head, tail;
  logic                  wr_en;
  logic [WIDTH-1:0]      mem_q [NUM];

  buffer_circular_ctrl #(
    .NUM          (NUM),
    .UMBRAL_LLENA (UMBRAL_LLENA),
    .UMBRAL_VACIA (UMBRAL_VACIA)
  ) u_ctrl (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .vaciar_i            (vaciar_i),
    .insercion_i         (insercion_i),
    .delecion_i          (delecion_i),
    .head_o              (head),
    .tail_o              (tail),
    .wr_en_o             (wr_en),
    .vacia_o             (vacia_o),
    .llena_o             (llena_o),
    .casi_llena_o        (casi_llena_o),
    .casi_vacia_o        (casi_vacia_o),
    .num_o               (num_o),
    .desbordamiento_o    (desbordamiento_o),
    .subdesbordamiento_o (subdesbordamiento_o)
  );

  // Storage carries data only, so it is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem_q[tail] <= dato_i;
  end

  assign dato_o = vacia_o ? '0 : mem_q[head];

endmodule

// File: tb/tb_buffer_circular_param.sv
// Scoreboard bench: NUM=8 and NUM=5 instances share stimulus, each tracked by its own queue model.
module tb_buffer_circular_param;

  logic        clk = 1'b0;
  logic        rst, vaciar, ins, del;
  logic [63:0] dato;
  logic [63:0] dato8, dato5;
  logic        vacia8, llena8, cll8, cva8, ovf8, udf8;
  logic        vacia5, llena5, cll5, cva5, ovf5, udf5;
  logic [3:0]  num8;
  logic [2:0]  num5;

  logic [63:0] q8[$];
  logic [63:0] q5[$];
  logic        m_ovf8, m_udf8, m_ovf5, m_udf5;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  buffer_circular_param #(.WIDTH(64), .NUM(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .vaciar_i(vaciar), .insercion_i(ins), .dato_i(dato),
    .delecion_i(del), .dato_o(dato8), .vacia_o(vacia8), .llena_o(llena8),
    .casi_llena_o(cll8), .casi_vacia_o(cva8), .num_o(num8),
    .desbordamiento_o(ovf8), .subdesbordamiento_o(udf8)
  );

  buffer_circular_param #(.WIDTH(64), .NUM(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .vaciar_i(vaciar), .insercion_i(ins), .dato_i(dato),
    .delecion_i(del), .dato_o(dato5), .vacia_o(vacia5), .llena_o(llena5),
    .casi_llena_o(cll5), .casi_vacia_o(cva5), .num_o(num5),
    .desbordamiento_o(ovf5), .subdesbordamiento_o(udf5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int s8, s5;
    s8 = q8.size();
    s5 = q5.size();
    chk("num8",   64'(num8),   64'(s8));
    chk("vacia8", 64'(vacia8), 64'(s8 == 0));
    chk("llena8", 64'(llena8), 64'(s8 == 8));
    chk("cll8",   64'(cll8),   64'(s8 >= 6));
    chk("cva8",   64'(cva8),   64'(s8 <= 1));
    chk("ovf8",   64'(ovf8),   64'(m_ovf8));
    chk("udf8",   64'(udf8),   64'(m_udf8));
    chk("head8",  dato8, (s8 == 0) ? 64'd0 : q8[0]);
    chk("num5",   64'(num5),   64'(s5));
    chk("vacia5", 64'(vacia5), 64'(s5 == 0));
    chk("llena5", 64'(llena5), 64'(s5 == 5));
    chk("cll5",   64'(cll5),   64'(s5 >= 3));
    chk("cva5",   64'(cva5),   64'(s5 <= 1));
    chk("ovf5",   64'(ovf5),   64'(m_ovf5));
    chk("udf5",   64'(udf5),   64'(m_udf5));
    chk("head5",  dato5, (s5 == 0) ? 64'd0 : q5[0]);
  endtask

  // One clock of stimulus: pops are compared before the edge, model advanced, state checked after
  task automatic cyc(input logic i_ins, input logic i_del, input logic [63:0] d, input logic i_vac);
    bit pd8, pi8, pd5, pi5;
    logic [63:0] e;
    ins = i_ins; del = i_del; dato = d; vaciar = i_vac;
    #1;
    pd8 = i_del && (q8.size() > 0);
    pi8 = i_ins && ((q8.size() < 8) || i_del);
    pd5 = i_del && (q5.size() > 0);
    pi5 = i_ins && ((q5.size() < 5) || i_del);
    if (!i_vac) begin
      if (i_ins && q8.size() == 8 && !i_del) m_ovf8 = 1'b1;
      if (i_del && q8.size() == 0)           m_udf8 = 1'b1;
      if (i_ins && q5.size() == 5 && !i_del) m_ovf5 = 1'b1;
      if (i_del && q5.size() == 0)           m_udf5 = 1'b1;
    end
    if (i_vac) begin
      q8.delete();
      q5.delete();
    end else begin
      if (pd8) begin e = q8.pop_front(); chk("pop8", dato8, e); end
      if (pd5) begin e = q5.pop_front(); chk("pop5", dato5, e); end
      if (pi8) q8.push_back(d);
      if (pi5) q5.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    ins = 1'b0; del = 1'b0; vaciar = 1'b0;
    #1;
    check_state();
  endtask

  // Requests are held high during reset to confirm they are ignored
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      rst = 1'b1; ins = 1'b1; del = 1'b1; dato = 64'hDEAD; vaciar = 1'b0;
      #1;
      chk("llena8_rst", 64'(llena8), 64'd1);
      chk("llena5_rst", 64'(llena5), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0; ins = 1'b0; del = 1'b0;
    q8.delete(); q5.delete();
    m_ovf8 = 1'b0; m_udf8 = 1'b0; m_ovf5 = 1'b0; m_udf5 = 1'b0;
    #1;
    check_state();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vaciar = 1'b0; ins = 1'b0; del = 1'b0; dato = '0;
    m_ovf8 = 1'b0; m_udf8 = 1'b0; m_ovf5 = 1'b0; m_udf5 = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Fill, full simultaneous insert/delete, drain, then underflow
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 64'h10 + 64'(i), 1'b0);
    cyc(1'b1, 1'b1, 64'hAA, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 64'd0, 1'b0);
    cyc(1'b0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 1'b1, 64'h33, 1'b0);
    cyc(1'b0, 1'b1, 64'd0, 1'b0);

    // Overflow on a full buffer, shrink to 3 entries, flush with a dropped insert
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 64'h20 + 64'(i), 1'b0);
    cyc(1'b1, 1'b0, 64'h99, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 1'b0, 64'h55, 1'b1);
    cyc(1'b1, 1'b0, 64'h01, 1'b0);
    cyc(1'b0, 1'b1, 64'd0, 1'b0);
    do_reset(1);

    // Interleaved traffic through the depth-5 pointer wrap
    cyc(1'b1, 1'b0, 64'd1, 1'b0);
    for (int i = 2; i <= 12; i++) cyc(1'b1, 1'b1, 64'(i), 1'b0);
    cyc(1'b0, 1'b1, 64'd0, 1'b0);
    cyc(1'b1, 1'b0, 64'd13, 1'b0);
    cyc(1'b1, 1'b0, 64'd14, 1'b0);
    cyc(1'b0, 1'b1, 64'd0, 1'b0);
    cyc(1'b0, 1'b1, 64'd0, 1'b0);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
          {$urandom, $urandom}, 1'($urandom_range(0, 39) == 0));
    do_reset(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/buffer_circular_param.md
Name: buffer_circular_param

Overview:
Parametrised next-generation circular FIFO for the lab datapath.
- Generalises width and depth, including non-power-of-two NUM.
- Adds simultaneous insert/delete when full, almost-full/almost-empty flags, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between a producer stage and a consumer stage as a decoupling buffer, with first-word-fall-through read.

Parameters:
- WIDTH, 64, data word width in bits (>=1).
- NUM, 8, number of entries (>=2; need not be a power of two).
- UMBRAL_LLENA, NUM-2, occupancy at or above which casi_llena_o asserts (1..NUM).
- UMBRAL_VACIA, 1, occupancy at or below which casi_vacia_o asserts (0..NUM-1).
- Derived localparam INDEX_SIZE = $clog2(NUM).
- Derived localparam COUNT_SIZE = $clog2(NUM+1).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- vaciar_i  in  1  synchronous flush.
- insercion_i  in  1  insert request.
- dato_i  in  WIDTH  data to insert.
- delecion_i  in  1  delete (pop) request.
- dato_o  out  WIDTH  head entry (first-word-fall-through).
- vacia_o  out  1  FIFO empty.
- llena_o  out  1  FIFO full.
- casi_llena_o  out  1  occupancy >= UMBRAL_LLENA.
- casi_vacia_o  out  1  occupancy <= UMBRAL_VACIA.
- num_o  out  COUNT_SIZE  current occupancy, 0..NUM.
- desbordamiento_o  out  1  sticky overflow error.
- subdesbordamiento_o  out  1  sticky underflow error.

Behaviour:
- Reset: one clock, one reset; reset is synchronous and active-high (clk_i, rst_i).
  - On a clk_i edge with rst_i=1: head, tail and count go to 0, and both sticky flags clear.
  - After the reset edge: vacia_o=1, casi_vacia_o=1, llena_o=0, casi_llena_o=0 (when UMBRAL_LLENA>0), num_o=0, dato_o=0, error flags 0.
  - While rst_i=1, llena_o is forced to 1 combinationally so upstream stalls. Inserts and deletes are ignored.
- Storage array is not reset; its contents are don't-care until written.
- Delete permission:
  - permiso_delecion = delecion_i & !vacia_o.
- Insert permission:
  - permiso_insercion = insercion_i & (!llena_o | delecion_i).
  - When full, a simultaneous delete frees the slot in the same cycle, so both complete and the count is unchanged.
- Empty with simultaneous insert+delete:
  - The delete is not permitted (no bypass).
  - The insert completes, and num goes 0->1.
- Write: on a permitted insert, mem[tail] <= dato_i at the clock edge.
- Read: dato_o = vacia_o ? 0 : mem[head], combinational, zero latency.
  - An inserted word is visible on dato_o the cycle after the insert edge.
- Pointers: head advances on a permitted delete; tail advances on a permitted insert.
  - Each wraps from NUM-1 to 0 by explicit compare, not by natural overflow.
- Count: num <= num + permiso_insercion - permiso_delecion, computed at COUNT_SIZE bits.
  - It never leaves the range 0..NUM.
- Flags, all combinational from num:
  - vacia_o = (num==0).
  - llena_o = (num==NUM) | rst_i.
  - casi_llena_o = (num>=UMBRAL_LLENA).
  - casi_vacia_o = (num<=UMBRAL_VACIA).
- Flush (vaciar_i=1, rst_i=0): head, tail and count go to 0 at the next edge.
  - Flush overrides insert and delete in the same cycle; that data is dropped.
  - Sticky error flags are not cleared by flush.
- Overflow: desbordamiento_o sets (sticky until reset) on any edge with insercion_i=1 & num==NUM & delecion_i=0 & vaciar_i=0.
- Underflow: subdesbordamiento_o sets (sticky until reset) on any edge with delecion_i=1 & num==0 & vaciar_i=0.
- Rejected requests change no state other than the sticky flag.
- Reset mid-operation: all queued data is lost; the FIFO reads empty after the reset edge.
- Reset has priority over flush.

Decomposition:
- Package buffer_circular_pkg holds:
  - Default constants: DEF_WIDTH=64, DEF_NUM=8.
  - Function siguiente_indice(idx, num) for wrap-around increment, shared with future multi-channel variants.
- Natural sub-module: buffer_circular_ctrl, containing the pointers, count, flags and error logic.
  - Top-level buffer_circular_param holds the storage array and the read mux, and instantiates the controller.

Test Plan:
- Reset then idle (NUM=8): hold rst_i=1 for 2 cycles, release -> vacia_o=1, llena_o=0, num_o=0, dato_o=0. During reset, llena_o=1.
- Fill and drain (NUM=8): insert 0x10..0x17 on 8 cycles -> llena_o=1, num_o=8, casi_llena_o=1 from num=6. Then delete 8 times -> dato_o sequence 0x10..0x17, then vacia_o=1.
- Full simultaneous (NUM=8): while full, insert 0xAA with delete -> num_o stays 8, dato_o advances to the second entry, 0xAA is read last, no overflow.
- Non-power-of-two wrap (NUM=5): 12 interleaved insert/delete pairs with values 1..12 -> output order 1..12 preserved across pointer wrap at index 4.
- Errors: insert with full and no delete -> desbordamiento_o=1, data unchanged. Delete while empty -> subdesbordamiento_o=1. Both flags survive vaciar_i and clear only on rst_i.
- Flush: with 3 entries, assert vaciar_i together with insercion_i=1 (0x55) -> next cycle num_o=0, vacia_o=1, and 0x55 is never read.
